// File: rtl/verinject_event_monitor.sv
// Watches CHANNELS injector-state buses and logs each injection as a cycle-stamped event in a FIFO.
// Latency: an event sampled at edge N is at the FIFO head after edge N; counters and flags update at edge N.
// Backpressure: log_valid/log_ready drain; a full FIFO without a same-cycle pop drops (VERINJECT_MONITOR_DISPLAY_EN adds prints).

module verinject_event_monitor_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             i_push_vld,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop_rdy,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == CW'(DEPTH));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push_vld) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (i_pop_rdy) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(i_push_vld) - CW'(i_pop_rdy);
        end
    end
endmodule

module verinject_event_monitor #(
    parameter int CHANNELS    = 4,
    parameter int CYCLE_WIDTH = 48,
    parameter int LOG_DEPTH   = 8,
    parameter int TOTAL_BITS  = 0
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic [32*CHANNELS-1:0]   verinject__injector_state,
    output logic [CYCLE_WIDTH-1:0]   cycle_number,
    output logic                     log_valid,
    input  logic                     log_ready,
    output logic [CYCLE_WIDTH-1:0]   log_cycle,
    output logic [3:0]               log_channel,
    output logic [31:0]              log_bit,
    output logic [31:0]              injection_count,
    output logic [15:0]              drop_count,
    output logic                     overflow,
    output logic                     range_error
);
    typedef struct packed {
        logic [CYCLE_WIDTH-1:0] cycle;
        logic [3:0]             channel;
        logic [31:0]            bit_idx;
    } evt_t;

    localparam int EVT_W = $bits(evt_t);
    // A zero limit means "no range check"; 2^32 can never be reached by a 32-bit index.
    localparam logic [32:0] RANGE_LIMIT = (TOTAL_BITS == 0) ? 33'h1_0000_0000 : 33'(TOTAL_BITS);

    logic [CYCLE_WIDTH-1:0] r_cycle;
    logic [31:0]            r_inj_cnt;
    logic [15:0]            r_drop_cnt;
    logic                   r_overflow;
    logic                   r_range_err;
    evt_t                   r_last;

    logic [CHANNELS-1:0]    w_active;
    logic [4:0]             w_num_active;
    logic [4:0]             w_num_drop;
    logic [3:0]             w_first_ch;
    logic [31:0]            w_first_bit;
    logic                   w_any_active;
    logic                   w_range_hit;
    logic                   w_fifo_empty;
    logic                   w_fifo_full;
    logic                   w_push;
    logic                   w_pop;
    logic [32:0]            w_inj_sum;
    logic [16:0]            w_drop_sum;
    evt_t                   w_push_dat;
    evt_t                   w_head_dat;

    // Scan from the top down so the lowest-indexed active channel wins the single log slot.
    always_comb begin
        w_active     = '0;
        w_num_active = '0;
        w_first_ch   = '0;
        w_first_bit  = '0;
        w_range_hit  = 1'b0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (verinject__injector_state[32*c +: 32] != 32'hFFFF_FFFF) begin
                w_active[c]  = 1'b1;
                w_num_active = w_num_active + 5'd1;
                w_first_ch   = 4'(c);
                w_first_bit  = verinject__injector_state[32*c +: 32];
                if ({1'b0, verinject__injector_state[32*c +: 32]} >= RANGE_LIMIT) begin
                    w_range_hit = 1'b1;
                end
            end
        end
    end

    assign w_any_active = |w_active;
    assign w_pop        = !w_fifo_empty && log_ready;
    assign w_push       = w_any_active && (!w_fifo_full || w_pop);
    assign w_num_drop   = w_num_active - {4'd0, w_push};
    assign w_inj_sum    = {1'b0, r_inj_cnt} + 33'(w_num_active);
    assign w_drop_sum   = {1'b0, r_drop_cnt} + 17'(w_num_drop);

    assign w_push_dat.cycle   = r_cycle;
    assign w_push_dat.channel = w_first_ch;
    assign w_push_dat.bit_idx = w_first_bit;

    verinject_event_monitor_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (LOG_DEPTH)
    ) u_log_fifo (
        .clock      (clock),
        .rst_n      (rst_n),
        .i_push_vld (w_push),
        .i_push_dat (w_push_dat),
        .i_pop_rdy  (w_pop),
        .o_head_dat (w_head_dat),
        .o_empty    (w_fifo_empty),
        .o_full     (w_fifo_full)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle     <= '0;
            r_inj_cnt   <= '0;
            r_drop_cnt  <= '0;
            r_overflow  <= 1'b0;
            r_range_err <= 1'b0;
            r_last      <= '0;
        end else begin
            r_cycle   <= r_cycle + CYCLE_WIDTH'(1);
            r_inj_cnt <= w_inj_sum[32] ? 32'hFFFF_FFFF : w_inj_sum[31:0];
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            if (w_num_drop != 5'd0) begin
                r_overflow <= 1'b1;
            end
            if (w_range_hit) begin
                r_range_err <= 1'b1;
            end
            if (w_pop) begin
                r_last <= w_head_dat;
            end
        end
    end

    // An empty FIFO shows the last popped event rather than stale storage.
    assign cycle_number    = r_cycle;
    assign log_valid       = !w_fifo_empty;
    assign log_cycle       = w_fifo_empty ? r_last.cycle   : w_head_dat.cycle;
    assign log_channel     = w_fifo_empty ? r_last.channel : w_head_dat.channel;
    assign log_bit         = w_fifo_empty ? r_last.bit_idx : w_head_dat.bit_idx;
    assign injection_count = r_inj_cnt;
    assign drop_count      = r_drop_cnt;
    assign overflow        = r_overflow;
    assign range_error     = r_range_err;

`ifdef VERINJECT_MONITOR_DISPLAY_EN
    always @(posedge clock) begin
        if (rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_active[c]) begin
                    $display("[verinject] cycle %0d channel %0d bit %0d",
                             r_cycle, c, verinject__injector_state[32*c +: 32]);
                    if (!(w_push && (4'(c) == w_first_ch))) begin
                        $display("[verinject] cycle %0d channel %0d event dropped", r_cycle, c);
                    end
                end
            end
        end
    end
`else
`endif
endmodule

// File: tb/tb_verinject_event_monitor.sv
// Directed bench for verinject_event_monitor: 4 channels, 16-bit cycle counter, depth 8, 100 injectable bits.
module tb_verinject_event_monitor;
    logic         clock = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] inj_state = '1;
    logic         log_ready = 1'b0;
    logic [15:0]  cycle_number;
    logic         log_valid;
    logic [15:0]  log_cycle;
    logic [3:0]   log_channel;
    logic [31:0]  log_bit;
    logic [31:0]  injection_count;
    logic [15:0]  drop_count;
    logic         overflow;
    logic         range_error;

    int tests_run = 0;
    int tests_failed = 0;

    verinject_event_monitor #(
        .CHANNELS    (4),
        .CYCLE_WIDTH (16),
        .LOG_DEPTH   (8),
        .TOTAL_BITS  (100)
    ) dut (
        .clock                     (clock),
        .rst_n                     (rst_n),
        .verinject__injector_state (inj_state),
        .cycle_number              (cycle_number),
        .log_valid                 (log_valid),
        .log_ready                 (log_ready),
        .log_cycle                 (log_cycle),
        .log_channel               (log_channel),
        .log_bit                   (log_bit),
        .injection_count           (injection_count),
        .drop_count                (drop_count),
        .overflow                  (overflow),
        .range_error               (range_error)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [31:0] v);
        inj_state[c*32 +: 32] = v;
    endtask

    // Leaves the DUT out of reset just after an edge with cycle_number = 0.
    task automatic do_reset();
        rst_n = 1'b0;
        inj_state = '1;
        log_ready = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        inj_state = '1;
        tick();
        tests_run++;
        if ({cycle_number, log_valid, log_cycle, log_channel, log_bit, injection_count, drop_count, overflow, range_error} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: cyc=%0d vld=%0b lc=%0d ch=%0d bit=%0d inj=%0d drop=%0d ovf=%0b rng=%0b, all required 0",
                     cycle_number, log_valid, log_cycle, log_channel, log_bit, injection_count, drop_count, overflow, range_error);
        end
        rst_n = 1'b1;
        repeat (10) tick();
        tests_run++;
        if (cycle_number !== 16'd10) begin tests_failed++; $display("FAIL idle_cycle: got %0d required 10", cycle_number); end
        tests_run++;
        if (log_valid !== 1'b0 || injection_count !== 32'd0 || drop_count !== 16'd0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_counts: vld=%0b inj=%0d drop=%0d ovf=%0b required 0", log_valid, injection_count, drop_count, overflow);
        end
    endtask

    task automatic test_single_event();
        do_reset();
        log_ready = 1'b1;
        repeat (3) tick();
        tests_run++;
        if (cycle_number !== 16'd3) begin tests_failed++; $display("FAIL single_pre_cycle: got %0d required 3", cycle_number); end
        set_ch(2, 32'd5);
        tick();
        inj_state = '1;
        tests_run++;
        if (log_valid !== 1'b1 || log_cycle !== 16'd3 || log_channel !== 4'd2 || log_bit !== 32'd5) begin
            tests_failed++;
            $display("FAIL single_head: vld=%0b cyc=%0d ch=%0d bit=%0d required 1/3/2/5", log_valid, log_cycle, log_channel, log_bit);
        end
        tick();
        tests_run++;
        if (log_valid !== 1'b0 || injection_count !== 32'd1 || log_cycle !== 16'd3 || log_bit !== 32'd5) begin
            tests_failed++;
            $display("FAIL single_after_pop: vld=%0b inj=%0d cyc=%0d bit=%0d required 0/1/3/5", log_valid, injection_count, log_cycle, log_bit);
        end
    endtask

    task automatic test_collision();
        do_reset();
        log_ready = 1'b1;
        repeat (2) tick();
        set_ch(0, 32'd7);
        set_ch(3, 32'd9);
        tick();
        inj_state = '1;
        tests_run++;
        if (log_valid !== 1'b1 || log_cycle !== 16'd2 || log_channel !== 4'd0 || log_bit !== 32'd7) begin
            tests_failed++;
            $display("FAIL collision_head: vld=%0b cyc=%0d ch=%0d bit=%0d required 1/2/0/7", log_valid, log_cycle, log_channel, log_bit);
        end
        tests_run++;
        if (injection_count !== 32'd2 || drop_count !== 16'd1 || overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL collision_counts: inj=%0d drop=%0d ovf=%0b required 2/1/1", injection_count, drop_count, overflow);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_ch(1, 32'(i));
            tick();
        end
        inj_state = '1;
        tests_run++;
        if (drop_count !== 16'd1 || injection_count !== 32'd9 || overflow !== 1'b1 || range_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_counts: drop=%0d inj=%0d ovf=%0b rng=%0b required 1/9/1/0", drop_count, injection_count, overflow, range_error);
        end
        log_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (log_valid !== 1'b1 || log_cycle !== 16'(i) || log_channel !== 4'd1 || log_bit !== 32'(i)) begin
                tests_failed++;
                $display("FAIL drain_order[%0d]: vld=%0b cyc=%0d ch=%0d bit=%0d required 1/%0d/1/%0d", i, log_valid, log_cycle, log_channel, log_bit, i, i);
            end
            tick();
        end
        tests_run++;
        if (log_valid !== 1'b0 || log_cycle !== 16'd7) begin
            tests_failed++;
            $display("FAIL drain_empty: vld=%0b cyc=%0d required 0/7", log_valid, log_cycle);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_ch(3, 32'(20 + i));
            tick();
        end
        tests_run++;
        if (log_cycle !== 16'd0 || log_bit !== 32'd20) begin
            tests_failed++;
            $display("FAIL b2b_full_head: cyc=%0d bit=%0d required 0/20", log_cycle, log_bit);
        end
        set_ch(3, 32'd50);
        log_ready = 1'b1;
        tick();
        inj_state = '1;
        tests_run++;
        if (drop_count !== 16'd0 || overflow !== 1'b0 || log_cycle !== 16'd1 || log_bit !== 32'd21) begin
            tests_failed++;
            $display("FAIL b2b_push_pop_full: drop=%0d ovf=%0b cyc=%0d bit=%0d required 0/0/1/21", drop_count, overflow, log_cycle, log_bit);
        end
        for (int i = 1; i < 8; i++) begin
            tests_run++;
            if (log_valid !== 1'b1 || log_cycle !== 16'(i) || log_bit !== 32'(20 + i)) begin
                tests_failed++;
                $display("FAIL b2b_drain[%0d]: vld=%0b cyc=%0d bit=%0d required 1/%0d/%0d", i, log_valid, log_cycle, log_bit, i, 20 + i);
            end
            tick();
        end
        tests_run++;
        if (log_valid !== 1'b1 || log_cycle !== 16'd8 || log_channel !== 4'd3 || log_bit !== 32'd50) begin
            tests_failed++;
            $display("FAIL b2b_last: vld=%0b cyc=%0d ch=%0d bit=%0d required 1/8/3/50", log_valid, log_cycle, log_channel, log_bit);
        end
        tick();
        tests_run++;
        if (log_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_empty: vld=%0b required 0", log_valid); end
    endtask

    task automatic test_range_and_reset();
        do_reset();
        log_ready = 1'b1;
        set_ch(1, 32'd99);
        tick();
        inj_state = '1;
        tests_run++;
        if (range_error !== 1'b0) begin tests_failed++; $display("FAIL range_99: got %0b required 0", range_error); end
        set_ch(1, 32'd100);
        tick();
        inj_state = '1;
        tests_run++;
        if (range_error !== 1'b1) begin tests_failed++; $display("FAIL range_100: got %0b required 1", range_error); end
        do_reset();
        tests_run++;
        if (range_error !== 1'b0) begin tests_failed++; $display("FAIL range_cleared: got %0b required 0", range_error); end
        log_ready = 1'b1;
        set_ch(0, 32'd1);
        set_ch(2, 32'd150);
        tick();
        inj_state = '1;
        log_ready = 1'b0;
        tests_run++;
        if (range_error !== 1'b1 || log_bit !== 32'd1 || drop_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL range_on_dropped: rng=%0b bit=%0d drop=%0d required 1/1/1", range_error, log_bit, drop_count);
        end
        set_ch(3, 32'd7);
        tick();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({cycle_number, log_valid, log_cycle, log_channel, log_bit, injection_count, drop_count, overflow, range_error} !== '0) begin
            tests_failed++;
            $display("FAIL midstream_reset: cyc=%0d vld=%0b lc=%0d ch=%0d bit=%0d inj=%0d drop=%0d ovf=%0b rng=%0b, all required 0",
                     cycle_number, log_valid, log_cycle, log_channel, log_bit, injection_count, drop_count, overflow, range_error);
        end
        do_reset();
    endtask

    task automatic test_drop_saturation();
        do_reset();
        for (int c = 0; c < 4; c++) set_ch(c, 32'd1);
        repeat (16385) tick();
        tests_run++;
        if (drop_count !== 16'd65532) begin tests_failed++; $display("FAIL drop_pre_sat: got %0d required 65532", drop_count); end
        tick();
        tests_run++;
        if (drop_count !== 16'hFFFF || injection_count !== 32'd65544) begin
            tests_failed++;
            $display("FAIL drop_sat: drop=%0d inj=%0d required 65535/65544", drop_count, injection_count);
        end
        repeat (5) tick();
        inj_state = '1;
        tests_run++;
        if (drop_count !== 16'hFFFF) begin tests_failed++; $display("FAIL drop_sat_hold: got %0d required 65535", drop_count); end
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (65535) tick();
        tests_run++;
        if (cycle_number !== 16'hFFFF) begin tests_failed++; $display("FAIL wrap_pre: got %0d required 65535", cycle_number); end
        tick();
        tests_run++;
        if (cycle_number !== 16'd0) begin tests_failed++; $display("FAIL wrap_zero: got %0d required 0", cycle_number); end
        set_ch(0, 32'd1);
        tick();
        inj_state = '1;
        tests_run++;
        if (log_valid !== 1'b1 || log_cycle !== 16'd0 || log_bit !== 32'd1) begin
            tests_failed++;
            $display("FAIL wrap_stamp: vld=%0b cyc=%0d bit=%0d required 1/0/1", log_valid, log_cycle, log_bit);
        end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_collision();
        test_overflow();
        test_back_to_back();
        test_range_and_reset();
        test_drop_saturation();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/verinject_event_monitor.md
# verinject_event_monitor

Simulation/emulation-side monitor for the verinject fault-injection framework, successor to the single-channel cycle-stamping monitor. It watches `CHANNELS` independent injector-state buses, keeps a free-running cycle counter, and records every injection as a timestamped event in a `LOG_DEPTH`-entry FIFO that a testbench or debug bridge drains over a valid/ready handshake. It also keeps saturating totals and flags dropped events and out-of-range bit indices.

## Interface
- `CHANNELS`, 4: number of injector-state buses watched, 1..16.
- `CYCLE_WIDTH`, 48: cycle counter width, 16..64.
- `LOG_DEPTH`, 8: event FIFO depth; power of two, ≥2.
- `TOTAL_BITS`, 0: number of injectable bits; 0 disables the range check.
- `clock`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `verinject__injector_state`  in  32*CHANNELS  channel c in bits [32c+31:32c]; all-ones = idle, any other value = bit index injected this cycle.
- `cycle_number`  out  CYCLE_WIDTH  current cycle count.
- `log_valid`  out  1  FIFO head holds an event.
- `log_ready`  in  1  consumer accepts the head this cycle.
- `log_cycle`  out  CYCLE_WIDTH  head event cycle stamp.
- `log_channel`  out  4  head event channel index.
- `log_bit`  out  32  head event bit index.
- `injection_count`  out  32  total detected events, saturating.
- `drop_count`  out  16  events not logged, saturating.
- `overflow`  out  1  sticky; set by any drop.
- `range_error`  out  1  sticky; set by any bit index ≥ TOTAL_BITS when TOTAL_BITS≠0.

## Operation
- Reset: `cycle_number`=0, FIFO empty, `log_valid`=0, `log_cycle`/`log_channel`/`log_bit`=0, `injection_count`=0, `drop_count`=0, `overflow`=0, `range_error`=0. Reset mid-operation discards all FIFO contents.
- `cycle_number` increments by 1 every cycle after reset release; wraps modulo 2^CYCLE_WIDTH with no flag.
- Per cycle, active channels = channels whose state ≠ 32'hFFFFFFFF.
- Stamp = `cycle_number` value during the sampling cycle, pre-increment.
- At most one event pushed per cycle: the lowest-indexed active channel. Other active channels that cycle are counted as drops.
- `injection_count` += number of active channels, saturating at 2^32−1.
- Push succeeds if FIFO not full, or full with a pop in the same cycle. Otherwise the event is dropped.
- `drop_count` += (unlogged actives), saturating at 65535. `overflow` is set when that sum is >0.
- `range_error` is checked on every active channel, logged or not.
- Pop occurs when `log_valid && log_ready`. `log_ready` with FIFO empty has no effect.
- Head fields are stable while `log_valid`=1 and no pop occurs. When the FIFO is empty they hold the last popped values (0 after reset).

## Timing
- Event sampled at edge N appears at the head with `log_valid`=1 in the cycle after edge N if the FIFO was empty. There is no bypass of the FIFO.
- Pop at edge N: the next entry is visible after edge N, with no bubble.
- Counters and sticky flags update at the same edge as the sampling.
- Simultaneous push and pop on an empty FIFO cannot occur; on a full FIFO, occupancy is unchanged.

## Configuration
- `VERINJECT_MONITOR_DISPLAY_EN` defined: each active channel produces a `$display` of cycle, channel and bit in the sampling cycle. Each drop adds a "dropped" message.
- Not defined: no simulation output; the block is synthesizable for emulation targets. Functional outputs are identical either way.

## Test plan
- Reset, idle all channels for 10 cycles: `cycle_number`=10, `log_valid`=0, all counts 0.
- Ch2 injects bit 5 at cycle 3, `log_ready`=1: head {cycle 3, ch 2, bit 5} valid one cycle later. After pop, `log_valid`=0 and `injection_count`=1.
- Ch0 and ch3 active in the same cycle: ch0 logged. `injection_count`=2, `drop_count`=1, `overflow`=1.
- `log_ready`=0, LOG_DEPTH=8, nine events on consecutive cycles: 8 logged, `drop_count`=1. Draining returns stamps in order.
- TOTAL_BITS=100, ch1 injects bit 100: `range_error`=1. Assert `rst_n` low mid-stream: all outputs return to their reset values immediately.
- CYCLE_WIDTH=16: after 65536 cycles `cycle_number` wraps to 0, and an event logged then carries stamp 0.
